demux_1_to_8_reg: RTL and testbench
===================================

Name: demux_1_to_8_reg

Overview:
- Registered 1-to-8 demultiplexer. It steers one N-bit input word to one of eight output channels selected by a 3-bit selector.
- Each channel has a single-entry holding register with a valid/ready handshake on both sides.
- It is the distribution counterpart of the 8-to-1 selection path. Uses: fanning a result bus out to eight destination stages or registers in the datapath with per-destination backpressure.

Parameters:
- N, 32, data width of the input word and of each output channel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present this cycle.
- in_ready  output  1  block can accept the word addressed by selector this cycle.
- selector  input  3  destination channel index, 3'b000..3'b111. Only meaningful when in_valid=1.
- in_data  input  N  word to deliver.
- out_valid  output  8  bit k set: channel k holds an undelivered word.
- out_ready  input  8  bit k set: consumer of channel k takes its word this cycle.
- out000, out001, out010, out011, out100, out101, out110, out111  output  N each  channel holding registers, indexed by selector value.
- accept_count  output  16  number of words accepted since reset; wraps 16'hFFFF -> 16'h0000.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=8'h00.
  - All eight out registers = 0.
  - accept_count=0.
  - Reset wins over any simultaneous handshake; a word offered during reset is not accepted.
- Channel state: each channel k is EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
- Drain, per channel k: if out_valid[k] and out_ready[k], the word is delivered. The channel goes EMPTY next cycle unless it is refilled in the same cycle.
- in_ready is combinational: in_ready = !out_valid[selector] | out_ready[selector].
  - It depends only on the addressed channel's state and its out_ready.
  - It does not depend on in_valid.
- Accept occurs when in_valid & in_ready at a clk edge. On the next cycle:
  - out[selector] <= in_data.
  - out_valid[selector] <= 1.
  - accept_count <= accept_count + 1, modulo 2^16.
- Latency: a word accepted at edge t is visible on out[sel] with out_valid[sel]=1 from edge t onward, i.e. usable in cycle t+1. There is no combinational path from in_data to any out port.
- Simultaneous drain and refill of the same channel: the new word replaces the old one, out_valid stays 1, and there is no bubble. This gives full throughput of one word per cycle per channel.
- Drain on channel j with accept on channel k (j != k): both happen independently in the same cycle.
- Unselected channels: data registers hold their value. A channel that goes EMPTY keeps its last data value; only out_valid clears.
- Full channel, no out_ready: in_ready=0 for that selector. The producer must hold in_valid, selector and in_data stable until accepted.
- If the producer changes selector while stalled, the new selector is evaluated fresh with no penalty. No word is ever lost or duplicated.
- selector with in_valid=0: no state change, even if in_ready=1.
- out_ready asserted on an EMPTY channel: ignored.
- Reset mid-operation: all undelivered words are discarded.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- When defined:
  - Adds input port broadcast (1 bit).
  - With in_valid=1 and broadcast=1, selector is ignored and the word targets all eight channels.
  - in_ready = AND over k of (!out_valid[k] | out_ready[k]).
  - On accept, all eight registers load in_data and out_valid becomes 8'hFF.
  - accept_count increments by 1, not 8.
  - broadcast=0 behaves exactly as the base block.
- When not defined: no broadcast port exists; behaviour is exactly the base block.

Test Plan:
- Reset: drive rst=1 with in_valid=1, selector=3'b010, in_data=32'hDEAD_BEEF. Then out_valid=8'h00, all outs=0 and accept_count=0 after the edge.
- Single route: in_valid=1, selector=3'b101, in_data=32'h1234_5678, out_ready=0. Then out101=32'h1234_5678, out_valid=8'b0010_0000 and accept_count=1 next cycle; all other outs unchanged.
- Backpressure: channel 3 FULL, out_ready[3]=0, offer selector=3'b011, data=32'hA5A5_A5A5. in_ready=0 and out011 keeps its old value. Raise out_ready[3] and the word is accepted that edge; out011=32'hA5A5_A5A5 with out_valid[3] still 1.
- Streaming: selector=3'b000 held, out_ready[0]=1, words 1,2,3,4 on consecutive cycles. in_ready=1 every cycle; out000 shows 1,2,3,4 on successive cycles; accept_count=4.
- Counter wrap: preload accept_count to 16'hFFFF via 65535 accepts. One more accept gives accept_count=16'h0000.
- Broadcast (DEMUX_BROADCAST_EN defined): broadcast=1, in_data=32'h0000_00FF with channel 6 FULL and out_ready[6]=0. Then in_ready=0. Release out_ready[6]=1 and after the edge all outs=32'h0000_00FF and out_valid=8'hFF.

Source files
------------

// File: rtl/demux_1_to_8_reg.sv
// ============================================================================
// demux_1_to_8_reg
// ----------------------------------------------------------------------------
// Registered 1-to-8 demultiplexer. One N-bit input word is steered to one of
// eight output channels chosen by a 3-bit selector. Each channel is a
// single-entry holding register with its own valid/ready handshake.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds its valid, selector and data stable while valid=1 and
//   ready=0. Ready never depends on the same side's valid. On the input side,
//   in_ready depends only on the addressed channel: the channel is empty, or
//   its consumer drains it this same cycle. This lets a full channel be
//   drained and refilled in one cycle with no bubble.
//
// Channel state:
//   Each channel k is EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
//   out_valid is the per-channel state vector and is visible directly on the
//   port, so no separate debug state output is needed.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   in_valid      input word present this cycle
//   in_ready      block can accept the addressed word this cycle (comb.)
//   selector[2:0] destination channel index
//   in_data[N-1:0] word to deliver
//   broadcast     (DEMUX_BROADCAST_EN only) target all eight channels
//   out_valid[7:0] channel k holds an undelivered word
//   out_ready[7:0] consumer of channel k takes its word this cycle
//   out000..out111 channel holding registers, indexed by selector value
//   accept_count[15:0] words accepted since reset, wraps at 2^16
//
// Optional feature:
//   DEMUX_BROADCAST_EN - when defined, adds the broadcast input. With
//   broadcast=1 the selector is ignored, the word is accepted only when all
//   eight channels can take it, and it is loaded into every channel. The
//   accept counter still advances by one per accepted word.
// ============================================================================
module demux_1_to_8_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   selector,
    input  logic [N-1:0] in_data,
`ifdef DEMUX_BROADCAST_EN
    input  logic         broadcast,
`endif
    output logic [7:0]   out_valid,
    input  logic [7:0]   out_ready,
    output logic [N-1:0] out000,
    output logic [N-1:0] out001,
    output logic [N-1:0] out010,
    output logic [N-1:0] out011,
    output logic [N-1:0] out100,
    output logic [N-1:0] out101,
    output logic [N-1:0] out110,
    output logic [N-1:0] out111,
    output logic [15:0]  accept_count
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [N-1:0] chan_data [8];
    logic [7:0]   chan_valid;
    logic [15:0]  count_q;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // A channel can take a word when it is empty or is being drained now.
    logic [7:0] chan_free;
    logic [7:0] drain;
    logic [7:0] sel_onehot;
    logic [7:0] load;
    logic       sel_ready;
    logic       accept;

    assign chan_free  = ~chan_valid | out_ready;
    // out_ready on an empty channel is ignored by masking with chan_valid.
    assign drain      = chan_valid & out_ready;
    assign sel_onehot = 8'b0000_0001 << selector;
    assign sel_ready  = chan_free[selector];

`ifdef DEMUX_BROADCAST_EN
    logic all_ready;
    assign all_ready = &chan_free;

    always_comb begin
        in_ready = sel_ready;
        load     = 8'h00;
        if (broadcast) begin
            in_ready = all_ready;
        end
        if (in_valid && in_ready) begin
            load = broadcast ? 8'hFF : sel_onehot;
        end
    end
`else
    always_comb begin
        in_ready = sel_ready;
        load     = 8'h00;
        if (in_valid && in_ready) begin
            load = sel_onehot;
        end
    end
`endif

    assign accept = in_valid & in_ready;

    // ------------------------------------------------------------------------
    // Channel registers
    // ------------------------------------------------------------------------
    // A load takes priority over a drain in the same cycle so a refilled
    // channel stays FULL; a drained channel keeps its last data value.
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_valid <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                chan_data[k] <= '0;
            end
        end else begin
            chan_valid <= (chan_valid & ~drain) | load;
            for (int k = 0; k < 8; k++) begin
                if (load[k]) begin
                    chan_data[k] <= in_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accept counter, wraps modulo 2^16
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'h0000;
        end else if (accept) begin
            count_q <= count_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered; no path from in_data to any out port)
    // ------------------------------------------------------------------------
    assign out_valid    = chan_valid;
    assign accept_count = count_q;
    assign out000       = chan_data[0];
    assign out001       = chan_data[1];
    assign out010       = chan_data[2];
    assign out011       = chan_data[3];
    assign out100       = chan_data[4];
    assign out101       = chan_data[5];
    assign out110       = chan_data[6];
    assign out111       = chan_data[7];

endmodule

// File: tb/tb_demux_1_to_8_reg.sv
// ============================================================================
// tb_demux_1_to_8_reg
// ----------------------------------------------------------------------------
// Directed testbench for demux_1_to_8_reg. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled at that point, away from the edge.
// Define DEMUX_BROADCAST_EN for both files to include the broadcast case.
// ============================================================================
module tb_demux_1_to_8_reg;

    localparam int N = 32;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   selector;
    logic [N-1:0] in_data;
`ifdef DEMUX_BROADCAST_EN
    logic         broadcast;
`endif
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [N-1:0] out000, out001, out010, out011;
    logic [N-1:0] out100, out101, out110, out111;
    logic [15:0]  accept_count;

    logic [N-1:0] outs [8];
    assign outs[0] = out000;
    assign outs[1] = out001;
    assign outs[2] = out010;
    assign outs[3] = out011;
    assign outs[4] = out100;
    assign outs[5] = out101;
    assign outs[6] = out110;
    assign outs[7] = out111;

    demux_1_to_8_reg #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .selector     (selector),
        .in_data      (in_data),
`ifdef DEMUX_BROADCAST_EN
        .broadcast    (broadcast),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out000       (out000),
        .out001       (out001),
        .out010       (out010),
        .out011       (out011),
        .out100       (out100),
        .out101       (out101),
        .out110       (out110),
        .out111       (out111),
        .accept_count (accept_count)
    );

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] sel, input logic [N-1:0] data);
        in_valid = 1'b1;
        selector = sel;
        in_data  = data;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [N-1:0] w;

        // Reset with a word offered: it must not be taken.
        rst       = 1'b1;
        out_ready = 8'h00;
`ifdef DEMUX_BROADCAST_EN
        broadcast = 1'b0;
`endif
        offer(3'b010, 32'hDEAD_BEEF);
        step();
        step();
        check("rst_valid", out_valid, 8'h00);
        check("rst_count", accept_count, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rst_out%0d", k), outs[k], 32'h0);
        end
        rst = 1'b0;
        idle();
        step();
        check("rst_release_valid", out_valid, 8'h00);

        // Single route to channel 5.
        offer(3'b101, 32'h1234_5678);
        check("single_ready", in_ready, 1'b1);
        step();
        idle();
        check("single_out101", out101, 32'h1234_5678);
        check("single_valid", out_valid, 8'b0010_0000);
        check("single_count", accept_count, 16'd1);
        check("single_out000", out000, 32'h0);

        // Selector with in_valid=0: nothing changes.
        selector = 3'b011;
        in_data  = 32'hFFFF_FFFF;
        step();
        check("idle_count", accept_count, 16'd1);
        check("idle_out011", out011, 32'h0);

        // out_ready on an empty channel is ignored.
        out_ready = 8'h01;
        step();
        check("empty_ready_valid", out_valid, 8'h20);
        out_ready = 8'h00;

        // Backpressure on channel 3.
        offer(3'b011, 32'h0000_0033);
        step();
        check("bp_fill_valid", out_valid, 8'h28);
        offer(3'b011, 32'hA5A5_A5A5);
        check("bp_stall_ready", in_ready, 1'b0);
        step();
        check("bp_stall_out011", out011, 32'h0000_0033);
        check("bp_stall_count", accept_count, 16'd2);
        out_ready = 8'b0000_1000;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        step();
        idle();
        out_ready = 8'h00;
        check("bp_refill_out011", out011, 32'hA5A5_A5A5);
        check("bp_refill_valid", out_valid, 8'h28);
        check("bp_refill_count", accept_count, 16'd3);

        // Stalled on channel 3, then redirected to empty channel 1.
        offer(3'b011, 32'h0000_0077);
        check("redir_stall_ready", in_ready, 1'b0);
        selector = 3'b001;
        #1;
        check("redir_ready", in_ready, 1'b1);
        step();
        idle();
        check("redir_out001", out001, 32'h0000_0077);
        check("redir_out011", out011, 32'hA5A5_A5A5);
        check("redir_valid", out_valid, 8'h2A);
        check("redir_count", accept_count, 16'd4);

        // Drain channel 5 while accepting into channel 7.
        out_ready = 8'h20;
        offer(3'b111, 32'h7777_0007);
        step();
        idle();
        out_ready = 8'h00;
        check("indep_valid", out_valid, 8'h8A);
        check("indep_out111", out111, 32'h7777_0007);
        check("indep_out101_kept", out101, 32'h1234_5678);
        check("indep_count", accept_count, 16'd5);

        // Streaming into channel 0 with the consumer always ready.
        out_ready = 8'h01;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(N'(i));
        end
        for (int i = 1; i <= 4; i++) begin
            offer(3'b000, N'(i));
            check($sformatf("stream_ready%0d", i), in_ready, 1'b1);
            step();
            w = exp_q.pop_front();
            check($sformatf("stream_out000_%0d", i), out000, w);
            check($sformatf("stream_valid%0d", i), out_valid[0], 1'b1);
        end
        idle();
        check("stream_count", accept_count, 16'd9);
        step();
        check("stream_drained_valid", out_valid, 8'h8A);
        check("stream_kept_out000", out000, 32'd4);

        // Counter wrap: accept until 16'hFFFF, then one more.
        offer(3'b000, 32'h0000_BEEF);
        repeat (65535 - 9) @(posedge clk);
        #1;
        check("wrap_ffff", accept_count, 16'hFFFF);
        step();
        idle();
        check("wrap_zero", accept_count, 16'h0000);

        // Reset mid-operation discards held words.
        rst = 1'b1;
        offer(3'b110, 32'h0000_0066);
        step();
        rst = 1'b0;
        idle();
        out_ready = 8'h00;
        check("midrst_valid", out_valid, 8'h00);
        check("midrst_count", accept_count, 16'h0000);
        check("midrst_out111", out111, 32'h0);

`ifdef DEMUX_BROADCAST_EN
        // Broadcast blocked by full channel 6, then released.
        offer(3'b110, 32'h0000_0066);
        step();
        check("bc_fill_valid", out_valid, 8'h40);
        broadcast = 1'b1;
        offer(3'b001, 32'h0000_00FF);
        check("bc_stall_ready", in_ready, 1'b0);
        step();
        check("bc_stall_valid", out_valid, 8'h40);
        check("bc_stall_out000", out000, 32'h0);
        out_ready = 8'h40;
        #1;
        check("bc_release_ready", in_ready, 1'b1);
        step();
        idle();
        broadcast = 1'b0;
        out_ready = 8'h00;
        check("bc_valid", out_valid, 8'hFF);
        check("bc_count", accept_count, 16'd2);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bc_out%0d", k), outs[k], 32'h0000_00FF);
        end
`endif

        // --------------------------------------------------------------------
        // Final report
        // --------------------------------------------------------------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
